// File: rtl/fc_layer_if.sv
// Start/done handshake, coefficient load port and result bus of the dense stage.
interface fc_layer_if #(
  parameter int IN_N   = 9,
  parameter int OUT_N  = 4,
  parameter int DATA_W = 32
);
  logic                    start;
  logic [IN_N*DATA_W-1:0]  in_fm;
  logic                    coef_we;
  logic [7:0]              coef_addr;
  logic [DATA_W-1:0]       coef_data;
  logic                    busy;
  logic                    done;
  logic [OUT_N*DATA_W-1:0] out_fm;

  modport master (
    output start, in_fm, coef_we, coef_addr, coef_data,
    input  busy, done, out_fm
  );

  modport slave (
    input  start, in_fm, coef_we, coef_addr, coef_data,
    output busy, done, out_fm
  );
endinterface

// File: rtl/fc_layer.sv
// Dense stage after the 2x2 average pool: one shared multiplier, IN_N+1 cycles
// per output neuron. Define FC_RELU_EN to clamp negative outputs to zero.
module fc_layer #(
  parameter int IN_N      = 9,
  parameter int OUT_N     = 4,
  parameter int DATA_W    = 32,
  parameter int FRAC_BITS = 16
) (
  input  logic      clk,
  input  logic      rst,
  fc_layer_if.slave bus
);
  localparam int COEF_N = OUT_N*IN_N + OUT_N;
  localparam int CW     = $clog2(COEF_N);
  localparam int JW     = (OUT_N > 1) ? $clog2(OUT_N) : 1;
  localparam int KW     = (IN_N > 1) ? $clog2(IN_N) : 1;
  localparam int PROD_W = 2*DATA_W;
  localparam int ACC_W  = PROD_W + 8;

  localparam logic signed [ACC_W-1:0] ONE_W    = {{(ACC_W-1){1'b0}}, 1'b1};
  localparam logic signed [ACC_W-1:0] HALF_LSB = ONE_W <<< (FRAC_BITS-1);
  localparam logic signed [ACC_W-1:0] SAT_MAX  = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN  = ~SAT_MAX;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_BIAS = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic [OUT_N*DATA_W-1:0]    out_q, out_d;
  logic [IN_N*DATA_W-1:0]     in_q, in_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic [JW-1:0]              j_q, j_d;
  logic [KW-1:0]              k_q, k_d;
  logic signed [DATA_W-1:0]   coef_q [COEF_N];
  logic signed [DATA_W-1:0]   coef_d [COEF_N];
  logic                       pend_vld_q, pend_vld_d;
  logic [CW-1:0]              pend_addr_q, pend_addr_d;
  logic [DATA_W-1:0]          pend_data_q, pend_data_d;

  logic signed [DATA_W-1:0]   in_k_s, w_s, b_s;
  logic [CW-1:0]              w_idx_s, b_idx_s, wr_idx_s;
  logic signed [PROD_W-1:0]   prod_s;
  logic signed [ACC_W-1:0]    rnd_s, shr_s, sum_s;
  logic signed [DATA_W-1:0]   sat_s, res_s;
  logic                       wr_ok_s;
  logic                       last_k_s, last_j_s;

  assign in_k_s   = in_q[k_q*DATA_W +: DATA_W];
  assign w_idx_s  = CW'(j_q) * CW'(IN_N) + CW'(k_q);
  assign b_idx_s  = CW'(OUT_N*IN_N) + CW'(j_q);
  assign w_s      = coef_q[w_idx_s];
  assign b_s      = coef_q[b_idx_s];
  assign prod_s   = PROD_W'(in_k_s) * PROD_W'(w_s);
  assign rnd_s    = acc_q + HALF_LSB;
  assign shr_s    = rnd_s >>> FRAC_BITS;
  assign sum_s    = shr_s + ACC_W'(b_s);
  assign last_k_s = (k_q == KW'(IN_N-1));
  assign last_j_s = (j_q == JW'(OUT_N-1));
  assign wr_ok_s  = bus.coef_we && (state_q == S_IDLE) && (bus.coef_addr < 8'(COEF_N));
  assign wr_idx_s = bus.coef_addr[CW-1:0];

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.out_fm = out_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = bus.start ? S_MAC : S_IDLE;
      S_MAC:   state_d = last_k_s ? S_BIAS : S_MAC;
      S_BIAS:  state_d = last_j_s ? S_IDLE : S_MAC;
      default: state_d = S_IDLE;
    endcase
  end

  // Round, add bias, saturate to the output word, optional ReLU
  always_comb begin
    if (sum_s > SAT_MAX) begin
      sat_s = SAT_MAX[DATA_W-1:0];
    end else if (sum_s < SAT_MIN) begin
      sat_s = SAT_MIN[DATA_W-1:0];
    end else begin
      sat_s = sum_s[DATA_W-1:0];
    end
`ifdef FC_RELU_EN
    res_s = sat_s[DATA_W-1] ? '0 : sat_s;
`else
    res_s = sat_s;
`endif
  end

  // Datapath and output controls per state
  always_comb begin
    busy_d      = busy_q;
    done_d      = done_q;
    out_d       = out_q;
    in_d        = in_q;
    acc_d       = acc_q;
    j_d         = j_q;
    k_d         = k_q;
    coef_d      = coef_q;
    pend_vld_d  = pend_vld_q;
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          in_d   = bus.in_fm;
          done_d = 1'b0;
          busy_d = 1'b1;
          j_d    = '0;
          k_d    = '0;
          acc_d  = '0;
        end else begin
          busy_d = 1'b0;
        end
        // A write coinciding with start is deferred so the launched pass sees the old value
        if (wr_ok_s) begin
          if (bus.start) begin
            pend_vld_d  = 1'b1;
            pend_addr_d = wr_idx_s;
            pend_data_d = bus.coef_data;
          end else begin
            coef_d[wr_idx_s] = bus.coef_data;
          end
        end else begin
          pend_vld_d = pend_vld_q;
        end
      end
      S_MAC: begin
        acc_d = acc_q + ACC_W'(prod_s);
        k_d   = last_k_s ? '0 : k_q + KW'(1'b1);
      end
      S_BIAS: begin
        out_d[j_q*DATA_W +: DATA_W] = res_s;
        acc_d = '0;
        k_d   = '0;
        if (last_j_s) begin
          busy_d = 1'b0;
          done_d = 1'b1;
          j_d    = '0;
          if (pend_vld_q) begin
            coef_d[pend_addr_q] = pend_data_q;
          end else begin
            coef_d = coef_q;
          end
          pend_vld_d = 1'b0;
        end else begin
          j_d = j_q + JW'(1'b1);
        end
      end
      default: begin
        busy_d = 1'b0;
        done_d = 1'b0;
      end
    endcase
  end

  // Datapath registers and coefficient file
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_q       <= '0;
      in_q        <= '0;
      acc_q       <= '0;
      j_q         <= '0;
      k_q         <= '0;
      coef_q      <= '{default: '0};
      pend_vld_q  <= 1'b0;
      pend_addr_q <= '0;
      pend_data_q <= '0;
    end else begin
      busy_q      <= busy_d;
      done_q      <= done_d;
      out_q       <= out_d;
      in_q        <= in_d;
      acc_q       <= acc_d;
      j_q         <= j_d;
      k_q         <= k_d;
      coef_q      <= coef_d;
      pend_vld_q  <= pend_vld_d;
      pend_addr_q <= pend_addr_d;
      pend_data_q <= pend_data_d;
    end
  end
endmodule

// File: doc/fc_layer.md
Name: fc_layer

Overview:
- Fully connected (dense) stage directly downstream of the 2x2 average-pooling stage.
- Consumes the pooled 3x3 feature map (9 signed fixed-point words) and produces OUT_N neuron outputs.
- Uses one multiplier, time-multiplexed, with a sequential multiply-accumulate per output neuron.
- Weights and biases are held in an internal coefficient file loaded through a simple write port; the start/done handshake matches the pooling stage.

Parameters:
- IN_N, 9, number of input activations (pooled 3x3 map, row-major).
- OUT_N, 4, number of output neurons.
- DATA_W, 32, signed word width of activations, weights, biases and outputs.
- FRAC_BITS, 16, fractional bits of the fixed-point format (Q15.16 default).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a pass; sampled only when not busy.
- in_fm  in  IN_N*DATA_W  flattened input map; element k at bits [k*DATA_W +: DATA_W].
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  8  0..OUT_N*IN_N-1 selects weight w[j][k] at j*IN_N+k; OUT_N*IN_N..OUT_N*IN_N+OUT_N-1 selects bias b[j].
- coef_data  in  DATA_W  coefficient value, signed, same Q format.
- busy  out  1  high while a pass is in progress.
- done  out  1  high from pass completion until the next accepted start.
- out_fm  out  OUT_N*DATA_W  flattened outputs; neuron j at bits [j*DATA_W +: DATA_W].

Behaviour:
- Reset: state IDLE; busy=0; done=0; out_fm all 0; accumulator 0; all weights and biases cleared to 0; j and k counters 0.
- States:
  - IDLE: on start, snapshot in_fm into an internal input register, clear done, set busy=1, j=0, k=0, acc=0, go to MAC.
  - MAC: acc += in[k]*w[j][k]. The full DATA_W x DATA_W signed product is 64 bits; the accumulator is 72 bits, sign-extended, so it never wraps. k increments; when k==IN_N-1, go to BIAS.
  - BIAS: r = (acc + 2^(FRAC_BITS-1)) >>> FRAC_BITS (arithmetic shift, round half up), then r += sign-extended b[j]. Saturate r to [-2^(DATA_W-1), 2^(DATA_W-1)-1] and write it to out_fm[j]. Then clear acc and k.
    - If j==OUT_N-1: busy=0, done=1, go to IDLE.
    - Else: j++, go to MAC.
- Latency: IN_N+1 cycles per neuron. done rises OUT_N*(IN_N+1) clock edges after the edge that accepts start; this is 40 with the defaults.
- out_fm[j] updates only in its BIAS cycle. Neurons not yet recomputed in the current pass keep their previous-pass values; outputs are only valid as a set while done=1.
- in_fm may change after start is accepted; the snapshot is used.
- start while busy is ignored. start held high in IDLE immediately re-launches a pass, and done drops on the accepting edge.
- coef_we while busy is ignored (no write). coef_we in IDLE writes on that edge. An out-of-range coef_addr is ignored.
- A simultaneous coef_we and start in IDLE both take effect, but the pass uses the pre-write coefficient value for that address.
- Reset mid-pass aborts immediately to the reset state; coefficients are lost.

Optional Feature:
- Macro: FC_RELU_EN.
- Defined: after saturation in BIAS, a negative r is written as 0 (ReLU), so out_fm values are always >= 0.
- Undefined: the saturated signed r is written unchanged.

Test Plan:
- All 36 weights = 65536 (1.0), biases 0, in_fm all 65536 → every out_fm[j] = 589824 (9.0); done rises exactly 40 edges after start is accepted; busy is high for those 40 cycles.
- Weights 0, biases b[j] = j*65536 → out_fm = 0, 65536, 131072, 196608; in_fm = 0x12345678 everywhere has no effect.
- Weights -65536, in_fm all 131072 (2.0), biases 0 → out_fm all -1179648 without FC_RELU_EN; all 0 with FC_RELU_EN.
- Saturation:
  - in_fm and weights all 0x7FFFFFFF → out_fm all 0x7FFFFFFF.
  - in_fm all 0x80000000 with weights all 0x7FFFFFFF → out_fm all 0x80000000 (ReLU off).
- During a pass, issue coef_we to addr 0 with 0 and change in_fm → the current pass is unaffected. A second pass shows the coefficient write was dropped.
- Assert rst at edge 15 of a pass → next cycle busy=0, done=0, out_fm all 0. Reload coefficients and restart → correct results after 40 edges.
